// File: rtl/i2c_dac_seq.sv
// MCP47FEB-style DAC write sequencer: turns (channel, value) requests into
// start/write_multiple/stop transactions on i2c_master. Optional NACK retry: DAC_NACK_RETRY_EN.
module i2c_dac_seq #(
  parameter int         CHANNELS  = 2,
  parameter int         CH_W      = 5,
  parameter int         DATA_BITS = 12,
  parameter logic [6:0] DEV_ADDR  = 7'h60,
  parameter int         TIMEOUT   = 65535,
  parameter int         MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CH_W-1:0]      req_channel,
  input  logic [DATA_BITS-1:0] req_value,
  output logic                 done,
  output logic                 nack_err,
  output logic                 range_err,
  output logic                 timeout_err,
  output logic                 busy,
  output logic [6:0]           cmd_address,
  output logic                 cmd_start,
  output logic                 cmd_read,
  output logic                 cmd_write,
  output logic                 cmd_write_multiple,
  output logic                 cmd_stop,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           data_in,
  output logic                 data_in_valid,
  input  logic                 data_in_ready,
  output logic                 data_in_last,
  input  logic                 i2c_busy,
  input  logic                 i2c_missed_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_CMD, S_D0, S_D1, S_D2, S_WHI, S_WLO, S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      chan_q, chan_d;
  logic [DATA_BITS-1:0] val_q, val_d;
  logic                 nack_q, nack_d, rng_q, rng_d, tmo_q, tmo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 on_bus, expired, accept, retry_fin, retry_next;
  logic [4:0]           ch5;
  logic [15:0]          val16;

  logic req_ready_q, req_ready_d, busy_q, busy_d, done_q, done_d;
  logic nack_err_q, nack_err_d, range_err_q, range_err_d, timeout_err_q, timeout_err_d;
  logic cmd_valid_q, cmd_valid_d, data_in_valid_q, data_in_valid_d;
  logic data_in_last_q, data_in_last_d;
  logic [7:0] data_in_q, data_in_d;

`ifdef DAC_NACK_RETRY_EN
  logic [7:0] retry_q, retry_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
`endif

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    val_d   = val_q;
    nack_d  = nack_q;
    rng_d   = rng_q;
    tmo_d   = tmo_q;
    on_bus  = state_q inside {S_CMD, S_D0, S_D1, S_D2, S_WHI, S_WLO};
    expired = on_bus && (cnt_q == CNT_W'(TIMEOUT - 1));
    accept  = (state_q == S_IDLE) && req_valid;
`ifdef DAC_NACK_RETRY_EN
    retry_d   = retry_q;
    retry_fin = nack_q && !tmo_q && !rng_q && (32'(retry_q) < 32'(MAX_RETRY));
`else
    retry_fin = 1'b0;
`endif

    if (on_bus && i2c_missed_ack) nack_d = 1'b1;

    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_CHK;
        chan_d  = req_channel;
        val_d   = req_value;
        nack_d  = 1'b0;
        rng_d   = 1'b0;
        tmo_d   = 1'b0;
      end
      S_CHK: begin
        if (32'(chan_q) >= 32'(CHANNELS)) begin
          rng_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_CMD;
        end
      end
      S_CMD: if (cmd_ready)     state_d = S_D0;
      S_D0:  if (data_in_ready) state_d = S_D1;
      S_D1:  if (data_in_ready) state_d = S_D2;
      S_D2:  if (data_in_ready) state_d = S_WHI;
      // A short transaction may finish before busy is ever seen high.
      S_WHI: begin
        if (i2c_busy)                     state_d = S_WLO;
        else if (cnt_q >= CNT_W'(2))      state_d = S_FIN;
      end
      S_WLO: if (!i2c_busy) state_d = S_FIN;
      S_FIN: begin
        state_d = retry_fin ? S_CMD : S_IDLE;
        if (retry_fin) nack_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout wins over any handshake completing in the same cycle.
    if (expired) begin
      state_d = S_FIN;
      tmo_d   = 1'b1;
    end

`ifdef DAC_NACK_RETRY_EN
    if (accept)                               retry_d = 8'd0;
    else if (state_q == S_FIN && retry_fin)   retry_d = retry_q + 8'd1;
    retry_next = nack_d && !tmo_d && !rng_d && (32'(retry_d) < 32'(MAX_RETRY));
`else
    retry_next = 1'b0;
`endif

    cnt_d = on_bus ? cnt_q + CNT_W'(1) : '0;
    if (state_d != state_q) cnt_d = '0;

    ch5   = 5'(chan_d);
    val16 = 16'(val_d);

    done_d          = (state_d == S_FIN) && !retry_next;
    range_err_d     = done_d && rng_d;
    timeout_err_d   = done_d && tmo_d && !rng_d;
    nack_err_d      = done_d && nack_d && !rng_d && !tmo_d;
    req_ready_d     = (state_d == S_IDLE);
    busy_d          = !req_ready_d;
    cmd_valid_d     = (state_d == S_CMD);
    data_in_valid_d = state_d inside {S_D0, S_D1, S_D2};
    data_in_last_d  = (state_d == S_D2);
    case (state_d)
      S_D0:    data_in_d = {ch5, 3'b000};
      S_D1:    data_in_d = val16[15:8];
      S_D2:    data_in_d = val16[7:0];
      default: data_in_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      chan_q          <= '0;
      val_q           <= '0;
      nack_q          <= 1'b0;
      rng_q           <= 1'b0;
      tmo_q           <= 1'b0;
      cnt_q           <= '0;
      req_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      nack_err_q      <= 1'b0;
      range_err_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
      cmd_valid_q     <= 1'b0;
      data_in_valid_q <= 1'b0;
      data_in_last_q  <= 1'b0;
      data_in_q       <= 8'h00;
`ifdef DAC_NACK_RETRY_EN
      retry_q         <= 8'd0;
`endif
    end else begin
      state_q         <= state_d;
      chan_q          <= chan_d;
      val_q           <= val_d;
      nack_q          <= nack_d;
      rng_q           <= rng_d;
      tmo_q           <= tmo_d;
      cnt_q           <= cnt_d;
      req_ready_q     <= req_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      nack_err_q      <= nack_err_d;
      range_err_q     <= range_err_d;
      timeout_err_q   <= timeout_err_d;
      cmd_valid_q     <= cmd_valid_d;
      data_in_valid_q <= data_in_valid_d;
      data_in_last_q  <= data_in_last_d;
      data_in_q       <= data_in_d;
`ifdef DAC_NACK_RETRY_EN
      retry_q         <= retry_d;
`endif
    end
  end

  assign req_ready          = req_ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign nack_err           = nack_err_q;
  assign range_err          = range_err_q;
  assign timeout_err        = timeout_err_q;
  assign cmd_address        = DEV_ADDR;
  assign cmd_valid          = cmd_valid_q;
  assign cmd_start          = cmd_valid_q;
  assign cmd_write_multiple = cmd_valid_q;
  assign cmd_stop           = cmd_valid_q;
  assign cmd_read           = 1'b0;
  assign cmd_write          = 1'b0;
  assign data_in            = data_in_q;
  assign data_in_valid      = data_in_valid_q;
  assign data_in_last       = data_in_last_q;

endmodule

// File: tb/tb_i2c_dac_seq.sv
// Bench for i2c_dac_seq: scripted i2c_master responder, per-cycle checker
// against a transaction-level model, and directed requests.
module tb_i2c_dac_seq;

  localparam int MAX_RETRY = 2;
  localparam int TMO       = 100;
  localparam int NCH       = 2;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_channel;
  logic [11:0] req_value;
  logic        done, nack_err, range_err, timeout_err, busy;
  logic [6:0]  cmd_address;
  logic        cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  data_in;
  logic        data_in_valid, data_in_ready, data_in_last;
  logic        i2c_busy, i2c_missed_ack;

  i2c_dac_seq #(.CHANNELS(NCH), .CH_W(5), .DATA_BITS(12), .DEV_ADDR(7'h60),
                .TIMEOUT(TMO), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_channel(req_channel), .req_value(req_value),
    .done(done), .nack_err(nack_err), .range_err(range_err),
    .timeout_err(timeout_err), .busy(busy),
    .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
    .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple),
    .cmd_stop(cmd_stop), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_in_last(data_in_last),
    .i2c_busy(i2c_busy), .i2c_missed_ack(i2c_missed_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected wire bytes of one write: register index in B0, value big-endian.
  function automatic logic [7:0] exp_byte(input int ch, input int val, input int idx);
    int b;
    if (idx == 0)      b = (ch % 32) * 8;
    else if (idx == 1) b = (val / 256) % 256;
    else               b = val % 256;
    return 8'(b);
  endfunction

  // responder configuration, written only by the main sequence
  int cmd_delay = 2, busy_len = 6, nack_att = 0, stall = 0;

  // i2c_master responder; acts 1 unit after the falling edge
  int s_phase = 0, s_cnt = 0, attempt = 0;
  initial begin
    cmd_ready = 0; data_in_ready = 0; i2c_busy = 0; i2c_missed_ack = 0;
    forever begin
      @(negedge clk); #1;
      cmd_ready = 0; data_in_ready = 0; i2c_missed_ack = 0;
      if (req_valid) attempt = 0;
      if (rst) begin
        s_phase = 0; s_cnt = 0; i2c_busy = 0;
      end else begin
        case (s_phase)
          0: if (cmd_valid && stall == 0) begin
               if (s_cnt >= cmd_delay) begin cmd_ready = 1; s_phase = 1; s_cnt = 0; end
               else s_cnt++;
             end
          1: if (data_in_valid) begin
               data_in_ready = s_cnt[0];
               s_cnt++;
               if (data_in_ready && data_in_last) begin s_phase = 2; s_cnt = 0; end
             end
          default: begin
            if (s_cnt < busy_len) begin
              i2c_busy = 1;
              i2c_missed_ack = (s_cnt == 1) && (attempt < nack_att);
              s_cnt++;
            end else begin
              i2c_busy = 0; attempt++; s_phase = 0; s_cnt = 0;
            end
          end
        endcase
      end
    end
  end

  // per-cycle checker and transaction log, sampled mid-cycle
  int cyc = 0, hs_cnt = 0, nbytes = 0, cv_cycles = 0, done_cnt = 0;
  int acc_cyc = 0, done_cyc = 0, bidx = 0, cur_ch = 0, cur_val = 0;
  logic inflight = 0;
  logic d_nack = 0, d_rng = 0, d_tmo = 0;
  logic [7:0] byte_log[$];

  always begin
    @(negedge clk); #2;
    cyc++;
    if (rst) begin
      inflight = 0; bidx = 0;
    end else begin
      chk("excl_valid", cmd_valid && data_in_valid, 0);
      chk("cmd_flags", {cmd_start, cmd_write_multiple, cmd_stop}, {3{cmd_valid}});
      chk("cmd_rw", {cmd_read, cmd_write}, 0);
      chk("addr", cmd_address, 7'h60);
      chk("req_ready", req_ready, !inflight);
      chk("busy", busy, inflight);
      chk("last_wo_valid", data_in_last && !data_in_valid, 0);
      if (cmd_valid) cv_cycles++;
      if (cmd_valid && cmd_ready) hs_cnt++;
      if (data_in_valid && data_in_ready) begin
        chk("byte", data_in, exp_byte(cur_ch, cur_val, bidx));
        chk("last", data_in_last, bidx == 2);
        byte_log.push_back(data_in);
        nbytes++;
        bidx = (bidx + 1) % 3;
      end
      if (done) begin
        chk("done_inflight", inflight, 1);
        chk("err_onehot", $countones({nack_err, range_err, timeout_err}) <= 1, 1);
        done_cnt++; done_cyc = cyc;
        d_nack = nack_err; d_rng = range_err; d_tmo = timeout_err;
        inflight = 0;
      end
      if (req_valid && req_ready) begin
        inflight = 1; acc_cyc = cyc; bidx = 0;
        cur_ch = int'(req_channel); cur_val = int'(req_value);
      end
    end
  end

  task automatic run_req(input int ch, input int val, input int n_nack, input int stl,
                         input int blen, input string tag, output int nb0, output int hsd);
    int d0, h0, c0, w, exp_hs;
    logic e_rng, e_tmo, e_nack;
    e_rng = (ch >= NCH); e_tmo = 0; e_nack = 0; exp_hs = 0;
    if (!e_rng && stl != 0) e_tmo = 1;
    else if (!e_rng) begin
`ifdef DAC_NACK_RETRY_EN
      exp_hs = ((n_nack < MAX_RETRY) ? n_nack : MAX_RETRY) + 1;
      e_nack = (n_nack > MAX_RETRY);
`else
      exp_hs = 1;
      e_nack = (n_nack > 0);
`endif
    end
    nack_att = n_nack; stall = stl; busy_len = blen;
    d0 = done_cnt; h0 = hs_cnt; c0 = cv_cycles; nb0 = nbytes;
    @(negedge clk);
    req_valid = 1; req_channel = 5'(ch); req_value = 12'(val);
    @(negedge clk);
    req_valid = 0;
    w = 0;
    while (done_cnt == d0 && w < 2000) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    stall = 0;
    hsd = hs_cnt - h0;
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_range_err"}, d_rng, e_rng);
    chk({tag, "_timeout_err"}, d_tmo, e_tmo);
    chk({tag, "_nack_err"}, d_nack, e_nack);
    chk({tag, "_cmds"}, hsd, exp_hs);
    chk({tag, "_bytes"}, nbytes - nb0, 3 * exp_hs);
    if (e_rng) begin
      chk({tag, "_latency"}, done_cyc - acc_cyc, 2);
      chk({tag, "_no_cmd"}, cv_cycles - c0, 0);
    end
    if (e_tmo) chk({tag, "_cmd_valid_cycles"}, cv_cycles - c0, TMO);
  endtask

  int nb0, hsd, d0, w, n0;

  initial begin
    rst = 1; req_valid = 0; req_channel = 0; req_value = 0;
    @(negedge clk); @(negedge clk); #3;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_data_valid", data_in_valid, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_last", data_in_last, 0);
    chk("rst_errs", {nack_err, range_err, timeout_err}, 0);
    chk("rst_addr", cmd_address, 7'h60);
    @(negedge clk); rst = 0;

    run_req(0, 'hABC, 0, 0, 6, "ch0", nb0, hsd);
    if (nbytes - nb0 >= 3) begin
      chk("lit_ch0_b0", byte_log[nb0],     8'h00);
      chk("lit_ch0_b1", byte_log[nb0 + 1], 8'h0A);
      chk("lit_ch0_b2", byte_log[nb0 + 2], 8'hBC);
    end
    run_req(1, 'h005, 0, 0, 6, "ch1", nb0, hsd);
    if (nbytes - nb0 >= 3) begin
      chk("lit_ch1_b0", byte_log[nb0],     8'h08);
      chk("lit_ch1_b1", byte_log[nb0 + 1], 8'h00);
      chk("lit_ch1_b2", byte_log[nb0 + 2], 8'h05);
    end
    run_req(3,  'h123, 0, 0, 6, "range3",  nb0, hsd);
    run_req(2,  'h456, 0, 0, 6, "range2",  nb0, hsd);
    run_req(31, 'hFFF, 0, 0, 6, "range31", nb0, hsd);
    run_req(0, 'hFFF, 1, 0, 6, "nack_once", nb0, hsd);
`ifdef DAC_NACK_RETRY_EN
    chk("lit_nack_once_cmds", hsd, 2);
`else
    chk("lit_nack_once_cmds", hsd, 1);
`endif
    run_req(1, 'h800, 99, 0, 6, "nack_all", nb0, hsd);
`ifdef DAC_NACK_RETRY_EN
    chk("lit_nack_all_cmds", hsd, 3);
`else
    chk("lit_nack_all_cmds", hsd, 1);
`endif
    run_req(1, 'h456, 0, 1, 6, "timeout", nb0, hsd);
    run_req(1, 'h321, 0, 0, 0, "fast_bus", nb0, hsd);

    // reset while the second byte is being offered
    d0 = done_cnt; n0 = nbytes; busy_len = 6; nack_att = 0;
    @(negedge clk);
    req_valid = 1; req_channel = 5'd1; req_value = 12'h123;
    @(negedge clk);
    req_valid = 0;
    w = 0;
    while (nbytes - n0 < 1 && w < 200) begin @(negedge clk); w++; end
    chk("rst_mid_reached_d1", nbytes - n0, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #3;
    chk("rst_mid_cmd_valid", cmd_valid, 0);
    chk("rst_mid_data_valid", data_in_valid, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    run_req(1, 'h7E1, 0, 0, 6, "after_rst", nb0, hsd);
    if (nbytes - nb0 >= 3) begin
      chk("lit_after_b0", byte_log[nb0],     8'h08);
      chk("lit_after_b1", byte_log[nb0 + 1], 8'h07);
      chk("lit_after_b2", byte_log[nb0 + 2], 8'hE1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_dac_seq.md
Name: i2c_dac_seq

Overview:
- Parametrised multi-channel DAC write sequencer sitting between user logic and the i2c_master command/data streams.
- Accepts (channel, value) requests and formats each as an MCP47FEB-style 3-byte write_multiple transaction with start and stop.
- Drives the transaction through i2c_master, tracks bus completion, and reports NACK, range and timeout errors.
- Replaces hand-sequenced cmd/data driving with a reusable block generalised in channel count, DAC resolution and device address.

Parameters:
- CHANNELS, 2, number of DAC channels (1..32); valid register index 0..CHANNELS-1.
- CH_W, 5, width of req_channel.
- DATA_BITS, 12, DAC resolution (8..16); value is right-justified.
- DEV_ADDR, 7'h60, 7-bit I2C device address.
- TIMEOUT, 65535, clk cycles allowed per wait state before abort.
- MAX_RETRY, 2, NACK retries; used only when DAC_NACK_RETRY_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  write request valid.
- req_ready  out  1  high in IDLE only.
- req_channel  in  CH_W  target DAC register index.
- req_value  in  DATA_BITS  DAC code.
- done  out  1  one-cycle pulse when a request completes, with or without error.
- nack_err  out  1  qualified by done; missed_ack seen during the transaction.
- range_err  out  1  qualified by done; channel >= CHANNELS.
- timeout_err  out  1  qualified by done; wait exceeded TIMEOUT.
- busy  out  1  high whenever not in IDLE.
- cmd_address  out  7  equals DEV_ADDR.
- cmd_start, cmd_write_multiple, cmd_stop  out  1 each  held high while cmd_valid is high.
- cmd_read, cmd_write  out  1 each  tied 0.
- cmd_valid  out  1  command strobe.
- cmd_ready  in  1  from i2c_master.
- data_in  out  8  byte to i2c_master.
- data_in_valid  out  1.
- data_in_ready  in  1.
- data_in_last  out  1  high on the third byte only.
- i2c_busy  in  1  i2c_master busy.
- i2c_missed_ack  in  1  i2c_master missed_ack.

Behaviour:
- Reset values: all outputs 0 except req_ready=1 and cmd_address=DEV_ADDR. State returns to IDLE from any state on the next clk with rst=1. Any transaction in flight is abandoned and no done pulse is generated.
- A request is accepted on req_valid && req_ready. The channel and value are registered and req_ready drops on the next cycle.
- Byte formatting:
  - B0 = {chan[4:0], 2'b00, 1'b0}.
  - {B1,B2} = 16-bit zero-extended value; B1 is the MSB byte.
- States:
  - IDLE: on accept, go to CHK.
  - CHK: if chan >= CHANNELS, pulse done with range_err=1 and go to IDLE; the bus is not touched. Otherwise go to CMD.
  - CMD: assert cmd_valid with start/write_multiple/stop high. Hold until cmd_ready, then drop cmd_valid and go to D0.
  - D0, D1, D2: present B0, B1, B2 with data_in_valid high. Each byte advances on data_in_valid && data_in_ready. data_in_last=1 only in D2. After the D2 handshake, data_in_valid drops and the state goes to WAIT_HI.
  - WAIT_HI: wait for i2c_busy=1, then go to WAIT_LO. If the bus already went idle because the transaction was faster than sampling, it is accepted on seeing i2c_busy=0 after at least 2 cycles in this state.
  - WAIT_LO: wait for i2c_busy=0, then go to FIN.
  - FIN: pulse done for 1 cycle with nack_err = sticky flag; go to IDLE.
- NACK flag: sticky. Cleared on accept; set if i2c_missed_ack=1 in any cycle from CMD through WAIT_LO.
- Timeout counter:
  - Counts cycles in CMD, D0-D2, WAIT_HI and WAIT_LO.
  - Resets on every state change.
  - On reaching TIMEOUT: drop cmd_valid and data_in_valid, pulse done with timeout_err=1, go to IDLE.
  - Timeout takes priority over a handshake completing in the same cycle.
- Error flags are mutually exclusive per done pulse. Priority order: range_err, then timeout_err, then nack_err.
- Latency: a range error gives done 2 cycles after accept. Otherwise latency is bus-bound.
- cmd_valid and data_in_valid are never high together.
- A back-to-back request is accepted the cycle after done, since req_ready rises with IDLE.

Optional Feature:
- DAC_NACK_RETRY_EN defined:
  - On FIN with the NACK flag set and retry count < MAX_RETRY, increment the count, clear the flag and re-enter CMD without a done pulse.
  - After MAX_RETRY failed retries, done with nack_err=1.
  - The retry count resets on accept.
- DAC_NACK_RETRY_EN undefined: no retry; MAX_RETRY is ignored.

Test Plan:
- Request ch=0, value=12'hABC, slave ACKs -> one command with start/write_multiple/stop; bytes 8'h00, 8'h0A, 8'hBC with last on 8'hBC; done=1 with all errors 0.
- Request ch=1, value=12'h005 -> bytes 8'h08, 8'h00, 8'h05; req_ready=0 until the cycle after done.
- Request ch=3 with CHANNELS=2 -> no cmd_valid; done with range_err=1 two cycles after accept.
- Slave NACKs the address (missed_ack pulses):
  - Macro undefined -> done with nack_err=1.
  - Macro defined, MAX_RETRY=2 -> exactly 3 commands, then nack_err=1.
  - Macro defined, ACK on the 2nd attempt -> 2 commands, then done with nack_err=0.
- Hold cmd_ready=0 with TIMEOUT=100 -> cmd_valid drops after 100 cycles; done with timeout_err=1.
- Assert rst for 1 cycle during D1 -> all valids 0, req_ready=1 next cycle, no done pulse; a new request then completes normally.
